// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache control interface: arbitrates dcache and icache
// requests onto one RAM port, with data priority and a starvation guard for fetches.
module cache_mem_responder #(
  parameter int DBURST_MAX = 4,
  parameter int ERRW       = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            dREN,
  input  logic            dWEN,
  input  logic [31:0]     daddr,
  input  logic [31:0]     dstore,
  output logic            dwait,
  output logic [31:0]     dload,
  input  logic            iREN,
  input  logic [31:0]     iaddr,
  output logic            iwait,
  output logic [31:0]     iload,
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  logic [1:0]      ramstate,
  output logic [ERRW-1:0] err_count,
  output logic [1:0]      dbg_state
);

  localparam int BW = $clog2(DBURST_MAX + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(DBURST_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   dburst, dburst_nxt;
  logic            d_req, d_own, i_own, d_done, i_done, grant, d_win;

  // Handshake: a requester holds its request, address and data stable until its wait
  // goes low; wait is low for exactly the one cycle the RAM reports ACCESS.
  always_comb begin
    d_req  = dREN | dWEN;
    d_own  = (state == DSERVE) & d_req;
    i_own  = (state == ISERVE) & iREN;
    d_done = d_own & (ramstate == RAM_ACCESS);
    i_done = i_own & (ramstate == RAM_ACCESS);
    grant  = (state == IDLE) | d_done | i_done;
  end

  // Arbitration sees the burst count including the completion happening this cycle.
  always_comb begin
    dburst_nxt = dburst;
    if (grant) begin
      if (i_done | ~iREN)
        dburst_nxt = '0;
      else if (d_done && dburst != BURST_CAP)
        dburst_nxt = dburst + BW'(1);
    end
    d_win = d_req & ~(iREN & (dburst_nxt == BURST_CAP));
    state_nxt = state;
    if (grant) begin
      if (d_win)
        state_nxt = DSERVE;
      else if (iREN)
        state_nxt = ISERVE;
      else
        state_nxt = IDLE;
    end else if (!d_own && !i_own) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dburst    <= '0;
      err_count <= '0;
    end else begin
      state  <= state_nxt;
      dburst <= dburst_nxt;
      if ((d_own | i_own) && ramstate == RAM_ERROR && err_count != '1)
        err_count <= err_count + ERRW'(1);
    end
  end

  // RAM port and cache-side responses follow the live request, so a withdrawal drops
  // the enables in the same cycle and a moving daddr passes straight through.
  always_comb begin
    ramWEN   = (state == DSERVE) & dWEN;
    ramREN   = ((state == DSERVE) & dREN & ~dWEN) | i_own;
    ramaddr  = '0;
    if (state == DSERVE)
      ramaddr = daddr;
    else if (state == ISERVE)
      ramaddr = iaddr;
    ramstore = ramWEN ? dstore : 32'd0;
    dwait    = ~d_done;
    iwait    = ~i_done;
    dload    = d_done ? ramload : 32'd0;
    iload    = i_done ? ramload : 32'd0;
    dbg_state = state;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a cycle model of the arbitration rules checks
// every output each cycle, a completion-order scoreboard and literal checks pin the model.
module tb_cache_mem_responder;

  localparam int DBURST_MAX = 4;
  localparam int ERRW       = 8;
  localparam int ERR_MAX    = (1 << ERRW) - 1;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            dREN, dWEN, iREN;
  logic [31:0]     daddr, dstore, iaddr;
  logic            dwait, iwait;
  logic [31:0]     dload, iload;
  logic            ramREN, ramWEN;
  logic [31:0]     ramaddr, ramstore, ramload;
  logic [1:0]      ramstate;
  logic [ERRW-1:0] err_count;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];   // expected completion order: 0 = data, 1 = instruction

  cache_mem_responder #(.DBURST_MAX(DBURST_MAX), .ERRW(ERRW)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- RAM stand-in ----------------
  int         ram_lat;
  int         lat_cnt;
  logic       ram_mode;
  logic [1:0] ram_force;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST)
      lat_cnt <= 0;
    else if ((ramREN || ramWEN) && ramstate != 2'd2)
      lat_cnt <= lat_cnt + 1;
    else
      lat_cnt <= 0;
  end

  assign ramstate = ram_mode ? ram_force :
                    ((ramREN || ramWEN) ? ((lat_cnt >= ram_lat) ? 2'd2 : 2'd1) : 2'd0);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_take(input logic [0:0] code);
    logic [0:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_order: completion %0d seen with none expected at %0t", code, $time);
    end else begin
      e = exp_q.pop_front();
      if (e !== code) begin
        errors++;
        $display("FAIL sb_order: got completion %0d expected %0d at %0t", code, e, $time);
      end
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  int m_owner = 0;   // 0 none, 1 data, 2 instruction
  int m_burst = 0;
  int m_err   = 0;

  always @(negedge CLK) begin : model_blk
    logic        dreq, dfin, ifin, live, e_wen, e_ren;
    logic [31:0] e_addr, e_store;
    if (!nRST) begin
      m_owner = 0;
      m_burst = 0;
      m_err   = 0;
    end
    dreq    = dREN || dWEN;
    e_wen   = (m_owner == 1) && dWEN;
    e_ren   = ((m_owner == 1) && dREN && !dWEN) || ((m_owner == 2) && iREN);
    e_addr  = (m_owner == 1) ? daddr : ((m_owner == 2) ? iaddr : 32'd0);
    e_store = e_wen ? dstore : 32'd0;
    dfin    = (m_owner == 1) && dreq && (ramstate == 2'd2);
    ifin    = (m_owner == 2) && iREN && (ramstate == 2'd2);
    check("m_ramWEN",   32'(ramWEN),    32'(e_wen));
    check("m_ramREN",   32'(ramREN),    32'(e_ren));
    check("m_ramaddr",  ramaddr,        e_addr);
    check("m_ramstore", ramstore,       e_store);
    check("m_dwait",    32'(dwait),     32'(!dfin));
    check("m_iwait",    32'(iwait),     32'(!ifin));
    check("m_dload",    dload,          dfin ? ramload : 32'd0);
    check("m_iload",    iload,          ifin ? ramload : 32'd0);
    check("m_err",      32'(err_count), 32'(m_err));
    if (nRST) begin
      live = ((m_owner == 1) && dreq) || ((m_owner == 2) && iREN);
      if (live && ramstate == 2'd3 && m_err < ERR_MAX)
        m_err = m_err + 1;
      if (m_owner == 0 || dfin || ifin) begin
        if (ifin || !iREN)
          m_burst = 0;
        else if (dfin && m_burst < DBURST_MAX)
          m_burst = m_burst + 1;
        if (dreq && !(iREN && m_burst == DBURST_MAX))
          m_owner = 1;
        else if (iREN)
          m_owner = 2;
        else
          m_owner = 0;
      end else if (!live) begin
        m_owner = 0;
      end
    end
  end

  // ---------------- completion scoreboard ----------------
  always @(negedge CLK) begin
    if (nRST) begin
      if (dwait === 1'b0) sb_take(1'b0);
      if (iwait === 1'b0) sb_take(1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    dREN = 1'b0;
    dWEN = 1'b0;
    iREN = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    nRST = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
    ram_mode = 1'b0; ram_force = 2'd0; ram_lat = 1;

    @(negedge CLK);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_err",   32'(err_count), 32'd0);
    check("rst_addr",  ramaddr, 32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // single read, one-cycle RAM latency
    exp_q.push_back(1'b0);
    daddr = 32'h40; dREN = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("t1_idle_ren", 32'(ramREN), 32'd0);
    tick(); @(negedge CLK);
    check("t1_busy_ren",  32'(ramREN), 32'd1);
    check("t1_busy_addr", ramaddr, 32'h40);
    check("t1_busy_wait", 32'(dwait), 32'd1);
    tick(); @(negedge CLK);
    check("t1_dwait", 32'(dwait), 32'd0);
    check("t1_dload", dload, 32'hDEADBEEF);
    check("t1_iwait", 32'(iwait), 32'd1);
    tick();
    quiet();

    // write with both enables set: write wins
    exp_q.push_back(1'b0);
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h12;
    tick(); @(negedge CLK);
    check("t2_wen",   32'(ramWEN), 32'd1);
    check("t2_ren",   32'(ramREN), 32'd0);
    check("t2_store", ramstore, 32'h12);
    tick(); @(negedge CLK);
    check("t2_dwait", 32'(dwait), 32'd0);
    tick();
    quiet();

    // simultaneous requests: data first, then instruction
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    ramload = 32'h11111111;
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h80; iaddr = 32'h200;
    tick(); tick(); @(negedge CLK);
    check("t3_dfirst", 32'(dwait), 32'd0);
    check("t3_iheld",  32'(iwait), 32'd1);
    tick();
    dREN = 1'b0;
    tick(); tick(); tick(); @(negedge CLK);
    check("t3_iwait", 32'(iwait), 32'd0);
    check("t3_iload", iload, 32'h11111111);
    tick();
    quiet();

    // starvation guard: four data grants, one forced fetch, data resumes
    ram_lat = 0;
    ramload = 32'h22222222;
    for (int k = 0; k < 4; k++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h400;
    tick(); tick(); tick(); tick(); @(negedge CLK);
    check("t4_d4", 32'(dwait), 32'd0);
    tick(); @(negedge CLK);
    check("t4_forced_i", 32'(iwait), 32'd0);
    check("t4_forced_d", 32'(dwait), 32'd1);
    check("t4_forced_a", ramaddr, 32'h400);
    tick(); @(negedge CLK);
    check("t4_resume", 32'(dwait), 32'd0);
    tick();
    quiet();
    ram_lat = 1;

    // RAM error retries, then saturation
    ram_mode = 1'b1; ram_force = 2'd0;
    exp_q.push_back(1'b0);
    dREN = 1'b1; daddr = 32'h44;
    tick(); ram_force = 2'd3;
    tick(); tick();
    tick(); ram_force = 2'd2;
    @(negedge CLK);
    check("t5_err3",  32'(err_count), 32'd3);
    check("t5_dwait", 32'(dwait), 32'd0);
    tick(); ram_force = 2'd0;
    quiet();
    ram_force = 2'd3; dREN = 1'b1;
    for (int k = 0; k < 301; k++) tick();
    @(negedge CLK);
    check("t5_sat",   32'(err_count), 32'd255);
    check("t5_held",  32'(ramREN), 32'd1);
    tick(); ram_force = 2'd2;
    exp_q.push_back(1'b0);
    @(negedge CLK);
    check("t5_done", 32'(dwait), 32'd0);
    tick(); ram_force = 2'd0;
    quiet();
    ram_mode = 1'b0;

    // fetch withdrawal while waiting
    ram_lat = 3;
    iREN = 1'b1; iaddr = 32'h500;
    tick(); @(negedge CLK);
    check("t6_iren",  32'(ramREN), 32'd1);
    check("t6_iaddr", ramaddr, 32'h500);
    tick(); iREN = 1'b0;
    @(negedge CLK);
    check("t6_drop_ren", 32'(ramREN), 32'd0);
    check("t6_drop_iw",  32'(iwait), 32'd1);
    tick(); @(negedge CLK);
    check("t6_idle", 32'(dbg_state), 32'd0);
    quiet();

    // asynchronous reset during a data access
    dREN = 1'b1; daddr = 32'h600;
    tick(); @(negedge CLK);
    check("t6_dserve", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_ren",   32'(ramREN), 32'd0);
    check("t6_rst_dwait", 32'(dwait), 32'd1);
    check("t6_rst_addr",  ramaddr, 32'd0);
    check("t6_rst_err",   32'(err_count), 32'd0);
    tick(); tick();
    nRST = 1'b1; dREN = 1'b0;
    tick(); tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
